// File: rtl/result_collector.sv
// ============================================================================
// Module      : result_collector
// Description : Collects skewed per-lane sums from a systolic array, de-skews
//               them into whole rows and buffers the rows in a small FIFO for
//               a downstream consumer. Each group of MATRIX_SIZE rows forms a
//               frame; the final row of a frame is tagged with row_last.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   clock, rising edge
//   reset       in   asynchronous active-high reset
//   sum_in      in   MATRIX_SIZE lanes of DATA_SIZE bits, lane j lags lane 0
//                    by j cycles (lane j at bits [j*DATA_SIZE +: DATA_SIZE])
//   sum_valid   in   lane 0 of sum_in is valid this cycle
//   space_ready out  a complete frame can be accepted
//   row_out     out  de-skewed row at the FIFO head
//   row_valid   out  row_out holds a valid row
//   row_ready   in   consumer accepts row_out
//   row_last    out  head row is the final row of its frame
//   overflow    out  sticky: a row was dropped because the FIFO was full
// Build option
//   RESULT_COLLECTOR_RELU_EN : when defined, negative lanes read out as zero
// ============================================================================
`default_nettype none

module result_collector #(
    parameter int MATRIX_SIZE = 2,
    parameter int DATA_SIZE   = 32,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [MATRIX_SIZE*DATA_SIZE-1:0] sum_in,
    input  logic                             sum_valid,
    output logic                             space_ready,
    output logic [MATRIX_SIZE*DATA_SIZE-1:0] row_out,
    output logic                             row_valid,
    input  logic                             row_ready,
    output logic                             row_last,
    output logic                             overflow
);

    localparam int ROW_W = MATRIX_SIZE * DATA_SIZE;
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW    = $clog2(FIFO_DEPTH + 1);
    localparam int SW    = $clog2(FIFO_DEPTH + MATRIX_SIZE + 1);
    localparam int RW    = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_COLLECT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [RW-1:0]    row_cnt_q, row_cnt_d;
    logic [CW-1:0]    count_q, count_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic [ROW_W:0]   mem_q [FIFO_DEPTH];

    logic [ROW_W-1:0] w_row;
    logic             w_push;
    logic [SW-1:0]    w_inflight;
    logic [SW-1:0]    w_occupancy;
    logic             w_row_last;
    logic             w_full;
    logic             w_pop;
    logic             w_accept;
    logic [ROW_W:0]   w_head;

    // ------------------------------------------------------------------
    // Lane alignment: lane j is sampled j cycles after lane 0, so it needs
    // MATRIX_SIZE-1-j further cycles to line up with the last lane, which
    // is taken straight from the input at the write edge.
    // ------------------------------------------------------------------
    generate
        for (genvar j = 0; j < MATRIX_SIZE; j++) begin : g_lane
            if (j == MATRIX_SIZE - 1) begin : g_direct
                assign w_row[j*DATA_SIZE +: DATA_SIZE] = sum_in[j*DATA_SIZE +: DATA_SIZE];
            end else begin : g_delay
                localparam int DEPTH = MATRIX_SIZE - 1 - j;
                logic [DATA_SIZE-1:0] dly_q [DEPTH];

                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        for (int k = 0; k < DEPTH; k++) begin
                            dly_q[k] <= '0;
                        end
                    end else begin
                        dly_q[0] <= sum_in[j*DATA_SIZE +: DATA_SIZE];
                        for (int k = 1; k < DEPTH; k++) begin
                            dly_q[k] <= dly_q[k-1];
                        end
                    end
                end

                assign w_row[j*DATA_SIZE +: DATA_SIZE] = dly_q[DEPTH-1];
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Valid pipe: a row is pushed MATRIX_SIZE-1 cycles after its lane 0
    // was valid. Every set stage is a row still on its way to the FIFO.
    // ------------------------------------------------------------------
    generate
        if (MATRIX_SIZE > 1) begin : g_vpipe
            logic [MATRIX_SIZE-2:0] vpipe_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    vpipe_q <= '0;
                end else begin
                    vpipe_q[0] <= sum_valid;
                    for (int k = 1; k < MATRIX_SIZE - 1; k++) begin
                        vpipe_q[k] <= vpipe_q[k-1];
                    end
                end
            end

            assign w_push = vpipe_q[MATRIX_SIZE-2];

            always_comb begin
                w_inflight = '0;
                for (int k = 0; k < MATRIX_SIZE - 1; k++) begin
                    w_inflight = w_inflight + SW'(vpipe_q[k]);
                end
            end
        end else begin : g_vpipe_none
            assign w_push     = sum_valid;
            assign w_inflight = '0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    assign w_row_last = (row_cnt_q == RW'(MATRIX_SIZE - 1));
    assign w_full     = (count_q == CW'(FIFO_DEPTH));
    assign row_valid  = (count_q != '0);
    assign w_pop      = row_valid && row_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // is still accepted then.
    assign w_accept   = w_push && (!w_full || w_pop);

    always_comb begin
        row_cnt_d  = row_cnt_q;
        count_d    = count_q + CW'(w_accept) - CW'(w_pop);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        // The frame position advances even for a dropped row so later
        // frames keep their row_last alignment.
        if (w_push) begin
            row_cnt_d = w_row_last ? '0 : row_cnt_q + 1'b1;
        end
        if (w_accept) begin
            wr_ptr_d = (wr_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = (rd_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (w_push && !w_accept) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_cnt_q  <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            row_cnt_q  <= row_cnt_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: nothing is visible until the count says so.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            mem_q[wr_ptr_q] <= {w_row_last, w_row};
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            // With a single-row frame the start and the end share one edge.
            S_IDLE:    if (sum_valid && !(w_push && w_row_last)) state_d = S_COLLECT;
            S_COLLECT: if (w_push && w_row_last)                 state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    assign w_occupancy = SW'(count_q) + w_inflight;

    always_comb begin
        space_ready = (state_q == S_IDLE) &&
                      (w_occupancy <= SW'(FIFO_DEPTH - MATRIX_SIZE));
    end

    // ------------------------------------------------------------------
    // Output side: head row, forced to zero while the FIFO is empty.
    // ------------------------------------------------------------------
    assign w_head   = mem_q[rd_ptr_q];
    assign row_last = row_valid && w_head[ROW_W];
    assign overflow = overflow_q;

    generate
        for (genvar j = 0; j < MATRIX_SIZE; j++) begin : g_out
            logic [DATA_SIZE-1:0] w_lane;
            assign w_lane = w_head[j*DATA_SIZE +: DATA_SIZE];
`ifdef RESULT_COLLECTOR_RELU_EN
            assign row_out[j*DATA_SIZE +: DATA_SIZE] =
                (row_valid && !w_lane[DATA_SIZE-1]) ? w_lane : '0;
`else
            assign row_out[j*DATA_SIZE +: DATA_SIZE] = row_valid ? w_lane : '0;
`endif
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_result_collector.sv
`default_nettype none

module tb_result_collector;

    localparam int M  = 2;
    localparam int DS = 32;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [63:0]   sum_in = '0;
    logic          sum_valid = 1'b0;
    logic          space_ready;
    logic [63:0]   row_out;
    logic          row_valid;
    logic          row_ready = 1'b0;
    logic          row_last;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    // Reference model state: a plain queue of {last, row} entries.
    logic [64:0] m_q[$];
    bit          m_pend;
    logic [31:0] m_pend_l0;
    int          m_frow;
    bit          m_collect;
    bit          m_ovf;

    result_collector #(
        .MATRIX_SIZE (M),
        .DATA_SIZE   (DS),
        .FIFO_DEPTH  (FD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sum_in      (sum_in),
        .sum_valid   (sum_valid),
        .space_ready (space_ready),
        .row_out     (row_out),
        .row_valid   (row_valid),
        .row_ready   (row_ready),
        .row_last    (row_last),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] exp_out(input logic [63:0] r);
        logic [63:0] v;
        v = r;
`ifdef RESULT_COLLECTOR_RELU_EN
        if (v[31]) v[31:0]  = '0;
        if (v[63]) v[63:32] = '0;
`endif
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        sum_valid = 1'b0;
        sum_in    = '0;
        row_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Drives one frame: row A = {a1,a0}, row B = {b1,b0}, lane 1 skewed.
    task automatic send(input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] b0, input logic [31:0] b1);
        sum_valid = 1'b1; sum_in = {32'h0, a0}; tick();
        sum_in = {a1, b0}; tick();
        sum_valid = 1'b0; sum_in = {b1, 32'h0}; tick();
        sum_in = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        for (int ph = 0; ph < 2; ph++) begin
            checks++; if (row_valid !== 1'b0) begin errors++; $display("FAIL reset_row_valid ph%0d: got %b want 0", ph, row_valid); end
            checks++; if (row_last !== 1'b0) begin errors++; $display("FAIL reset_row_last ph%0d: got %b want 0", ph, row_last); end
            checks++; if (row_out !== 64'h0) begin errors++; $display("FAIL reset_row_out ph%0d: got %h want 0", ph, row_out); end
            checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow ph%0d: got %b want 0", ph, overflow); end
            checks++; if (space_ready !== 1'b1) begin errors++; $display("FAIL reset_space_ready ph%0d: got %b want 1", ph, space_ready); end
            tick();
            reset = 1'b0;
            tick();
        end
    endtask

    task automatic test_basic();
        do_reset();
        row_ready = 1'b1;
        sum_valid = 1'b1; sum_in = {32'd0, 32'd1}; tick();
        checks++; if (row_valid !== 1'b0) begin errors++; $display("FAIL basic_c1_valid: got %b want 0", row_valid); end
        sum_in = {32'd3, 32'd2}; tick();
        checks++; if (row_valid !== 1'b1) begin errors++; $display("FAIL basic_c2_valid: got %b want 1", row_valid); end
        checks++; if (row_out !== {32'd3, 32'd1}) begin errors++; $display("FAIL basic_c2_row: got %h want %h", row_out, {32'd3, 32'd1}); end
        checks++; if (row_last !== 1'b0) begin errors++; $display("FAIL basic_c2_last: got %b want 0", row_last); end
        sum_valid = 1'b0; sum_in = {32'd4, 32'd0}; tick();
        checks++; if (row_valid !== 1'b1) begin errors++; $display("FAIL basic_c3_valid: got %b want 1", row_valid); end
        checks++; if (row_out !== {32'd4, 32'd2}) begin errors++; $display("FAIL basic_c3_row: got %h want %h", row_out, {32'd4, 32'd2}); end
        checks++; if (row_last !== 1'b1) begin errors++; $display("FAIL basic_c3_last: got %b want 1", row_last); end
        sum_in = '0; tick();
        checks++; if (row_valid !== 1'b0) begin errors++; $display("FAIL basic_c4_valid: got %b want 0", row_valid); end
        checks++; if (space_ready !== 1'b1) begin errors++; $display("FAIL basic_c4_space: got %b want 1", space_ready); end
    endtask

    task automatic test_fill_overflow();
        logic [63:0] r [6];
        do_reset();
        for (int i = 0; i < 6; i++) r[i] = {$urandom, $urandom};
        send(r[0][31:0], r[0][63:32], r[1][31:0], r[1][63:32]);
        checks++; if (space_ready !== 1'b1) begin errors++; $display("FAIL fill_space_half: got %b want 1", space_ready); end
        send(r[2][31:0], r[2][63:32], r[3][31:0], r[3][63:32]);
        checks++; if (space_ready !== 1'b0) begin errors++; $display("FAIL fill_space_full: got %b want 0", space_ready); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_no_overflow: got %b want 0", overflow); end
        send(r[4][31:0], r[4][63:32], r[5][31:0], r[5][63:32]);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow_set: got %b want 1", overflow); end
        row_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (row_valid !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d]: got %b want 1", i, row_valid); end
            checks++; if (row_out !== exp_out(r[i])) begin errors++; $display("FAIL drain_row[%0d]: got %h want %h", i, row_out, exp_out(r[i])); end
            checks++; if (row_last !== 1'(i % 2)) begin errors++; $display("FAIL drain_last[%0d]: got %b want %0d", i, row_last, i % 2); end
            tick();
        end
        checks++; if (row_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b want 0", row_valid); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_full_passthrough();
        logic [63:0] r [6];
        logic [64:0] got[$];
        do_reset();
        for (int i = 0; i < 6; i++) r[i] = {$urandom, $urandom};
        send(r[0][31:0], r[0][63:32], r[1][31:0], r[1][63:32]);
        send(r[2][31:0], r[2][63:32], r[3][31:0], r[3][63:32]);
        for (int i = 0; i < 10; i++) begin
            row_ready = (i >= 1);
            case (i)
                0:       begin sum_valid = 1'b1; sum_in = {32'h0, r[4][31:0]}; end
                1:       begin sum_valid = 1'b1; sum_in = {r[4][63:32], r[5][31:0]}; end
                2:       begin sum_valid = 1'b0; sum_in = {r[5][63:32], 32'h0}; end
                default: begin sum_valid = 1'b0; sum_in = '0; end
            endcase
            if (row_valid && row_ready) got.push_back({row_last, row_out});
            tick();
        end
        checks++; if (got.size() != 6) begin errors++; $display("FAIL pass_count: got %0d want 6", got.size()); end
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== {1'(i % 2), exp_out(r[i])}) begin
                errors++; $display("FAIL pass_row[%0d]: got %h want %h", i, got[i], {1'(i % 2), exp_out(r[i])});
            end
        end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL pass_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_mid_reset();
        logic [63:0] a, b;
        do_reset();
        row_ready = 1'b1;
        sum_valid = 1'b1; sum_in = {$urandom, $urandom}; tick();
        sum_in = {$urandom, $urandom};
        reset = 1'b1;
        #1;
        checks++; if (space_ready !== 1'b1) begin errors++; $display("FAIL midrst_space_now: got %b want 1", space_ready); end
        tick();
        reset = 1'b0; sum_valid = 1'b0; sum_in = '0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (row_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_row[%0d]: got %b want 0", i, row_valid); end
            checks++; if (space_ready !== 1'b1) begin errors++; $display("FAIL midrst_space[%0d]: got %b want 1", i, space_ready); end
            tick();
        end
        row_ready = 1'b0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        send(a[31:0], a[63:32], b[31:0], b[63:32]);
        row_ready = 1'b1;
        checks++; if ({row_valid, row_last, row_out} !== {2'b10, exp_out(a)}) begin errors++; $display("FAIL midrst_row0: got %b%b %h want 10 %h", row_valid, row_last, row_out, exp_out(a)); end
        tick();
        checks++; if ({row_valid, row_last, row_out} !== {2'b11, exp_out(b)}) begin errors++; $display("FAIL midrst_row1: got %b%b %h want 11 %h", row_valid, row_last, row_out, exp_out(b)); end
        tick();
    endtask

`ifdef RESULT_COLLECTOR_RELU_EN
    task automatic test_relu();
        do_reset();
        send(32'hFFFFFFFF, 32'd5, 32'd7, 32'h80000000);
        checks++; if (row_out !== {32'd5, 32'd0}) begin errors++; $display("FAIL relu_row0: got %h want %h", row_out, {32'd5, 32'd0}); end
        row_ready = 1'b1; tick();
        checks++; if (row_out !== {32'd0, 32'd7}) begin errors++; $display("FAIL relu_row1: got %h want %h", row_out, {32'd0, 32'd7}); end
        tick();
    endtask
`endif

    task automatic test_random();
        int          sv_left;
        bit          pop;
        bit          nl;
        bit          e_space;
        bit          e_valid;
        logic [63:0] e_row;
        bit          e_last;
        int          n;
        do_reset();
        m_q.delete(); m_pend = 0; m_pend_l0 = '0; m_frow = 0; m_collect = 0; m_ovf = 0;
        sv_left = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            e_valid = (m_q.size() != 0);
            e_row   = e_valid ? exp_out(m_q[0][63:0]) : 64'h0;
            e_last  = e_valid && m_q[0][64];
            e_space = !m_collect && ((m_q.size() + int'(m_pend)) <= FD - M);
            checks++; if (row_valid !== e_valid) begin errors++; $display("FAIL rnd_valid@%0d: got %b want %b", cyc, row_valid, e_valid); end
            checks++; if (row_out !== e_row) begin errors++; $display("FAIL rnd_row@%0d: got %h want %h", cyc, row_out, e_row); end
            checks++; if (row_last !== e_last) begin errors++; $display("FAIL rnd_last@%0d: got %b want %b", cyc, row_last, e_last); end
            checks++; if (space_ready !== e_space) begin errors++; $display("FAIL rnd_space@%0d: got %b want %b", cyc, space_ready, e_space); end
            checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_overflow@%0d: got %b want %b", cyc, overflow, m_ovf); end

            if (sv_left == 0 && $urandom_range(0, 2) == 0 &&
                (e_space || $urandom_range(0, 9) == 0)) sv_left = M;
            sum_valid = (sv_left > 0);
            if (sv_left > 0) sv_left--;
            sum_in    = {$urandom, $urandom};
            row_ready = 1'($urandom_range(0, 1));

            // Model step for the coming edge.
            n   = m_q.size();
            pop = (n != 0) && row_ready;
            nl  = (m_frow == M - 1);
            if (pop) void'(m_q.pop_front());
            if (m_pend) begin
                if (n < FD || pop) m_q.push_back({nl, sum_in[63:32], m_pend_l0});
                else               m_ovf = 1;
                m_frow = (m_frow + 1) % M;
            end
            if (m_collect) begin
                if (m_pend && nl) m_collect = 0;
            end else if (sum_valid) begin
                m_collect = 1;
            end
            m_pend    = sum_valid;
            m_pend_l0 = sum_in[31:0];
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill_overflow();
        test_full_passthrough();
        test_mid_reset();
`ifdef RESULT_COLLECTOR_RELU_EN
        test_relu();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
